fxp_mult_seq: RTL and testbench

- Parametrised fixed-point multiplier for the equalizer datapath; successor to the 16-bit single-format combinational multiplier.
- Supports both operand formats: sign-magnitude and two's complement.
- Output is rescaled by a configurable number of fractional bits, then optionally rounded and saturated.
- Iterative shift-add core (one multiplier bit per cycle) with valid/ready handshakes on both sides; sits between the tap-coefficient store and the accumulator.

---
 rtl/fxp_mult_seq.sv | 127 ++++++++++++
 tb/tb_fxp_mult_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fxp_mult_seq.sv
// Sequential fixed-point multiplier with rescale, optional rounding, and saturation; sign-magnitude or two's complement.
// Latency: W+1 cycles from operand accept to out_valid; initiation interval W+3 with out_ready held high.
// Backpressure: the result is held in DONE until out_ready; in_ready stays low from accept until the result handshake.
module fxp_mult_seq #(
  parameter int W   = 16,
  parameter int F   = 15,
  parameter int FMT = 0,
  parameter int RND = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int FR = (F > 0) ? F - 1 : 0;
  // Rounding constant: half an output LSB, added to the magnitude before the shift.
  localparam logic [2*W-1:0] RADD    = (RND != 0 && F > 0) ? ((2*W)'(1) << FR) : '0;
  localparam logic [2*W-1:0] LIM_POS = ((2*W)'(1) << (W - 1)) - (2*W)'(1);
  localparam logic [2*W-1:0] LIM_NEG = (2*W)'(1) << (W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ROUND, DONE} state_t;

  state_t         state;
  logic           s;
  logic [W-1:0]   ma;
  logic [W-1:0]   mb;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] m_full;
  logic [2*W-1:0] lim;
  logic           sat;
  logic [W-1:0]   m;
  logic [W-1:0]   c_nxt;

  assign in_ready = (state == IDLE);

  // Operand magnitudes, W bits wide so the most negative TC value keeps its full magnitude.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (FMT == 0) begin
      a_mag = {1'b0, a[W-2:0]};
      b_mag = {1'b0, b[W-2:0]};
    end else begin
      if (a[W-1]) a_mag = -a;
      if (b[W-1]) b_mag = -b;
    end
  end

  // Rescale, round, saturate, and re-encode the finished product into the output format.
  always_comb begin
    acc_r  = acc + RADD;
    m_full = acc_r >> F;
    lim    = (FMT != 0 && s) ? LIM_NEG : LIM_POS;
    sat    = (m_full > lim);
    m      = sat ? lim[W-1:0] : m_full[W-1:0];
    c_nxt  = '0;
    if (FMT == 0) begin
      // Zero magnitude always encodes as +0 so negative zero never leaves the block.
      if (m != '0) c_nxt = {s, m[W-2:0]};
    end else begin
      c_nxt = s ? -m : m;
    end
  end

  // Control FSM with shift-add datapath; one multiplier bit is consumed per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      cnt       <= '0;
      c         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s     <= a[W-1] ^ b[W-1];
            ma    <= a_mag;
            mb    <= b_mag;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mb[cnt]) acc <= acc + ({{W{1'b0}}, ma} << cnt);
          if (cnt == CW'(W - 1)) begin
            state <= ROUND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ROUND: begin
          c         <= c_nxt;
          ovf       <= sat;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_mult_seq.sv
// Directed bench for fxp_mult_seq: three instances (SM truncate, TC truncate, TC round) at W=16, F=15.
// Checks reset state, latency, products, saturation, backpressure, and mid-operation reset.
// Every observed value is compared with a hand-computed constant.
module tb_fxp_mult_seq;

  logic        clk;
  logic        rst;
  logic        in_valid_v  [3];
  logic        in_ready_v  [3];
  logic [15:0] a_v         [3];
  logic [15:0] b_v         [3];
  logic        out_valid_v [3];
  logic        out_ready_v [3];
  logic [15:0] c_v         [3];
  logic        ovf_v       [3];

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fxp_mult_seq #(.W(16), .F(15), .FMT(0), .RND(0)) u_sm (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .c(c_v[0]), .ovf(ovf_v[0])
  );

  fxp_mult_seq #(.W(16), .F(15), .FMT(1), .RND(0)) u_tc (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .c(c_v[1]), .ovf(ovf_v[1])
  );

  fxp_mult_seq #(.W(16), .F(15), .FMT(1), .RND(1)) u_tcr (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .c(c_v[2]), .ovf(ovf_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance k with out_ready high; checks latency, result, and one-cycle valid.
  task automatic run(input int k, input logic [15:0] av, input logic [15:0] bv,
                     input logic [15:0] ec, input logic eo, input string tag);
    int t;
    @(negedge clk);
    t = 0;
    while (!in_ready_v[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " in_ready"}, 32'(in_ready_v[k]), 32'd1);
    a_v[k] = av;
    b_v[k] = bv;
    in_valid_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    a_v[k] = ~av;
    b_v[k] = ~bv;
    t = 0;
    while (!out_valid_v[k] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " latency"}, 32'(t), 32'd17);
    chk({tag, " c"}, 32'(c_v[k]), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf_v[k]), 32'(eo));
    @(negedge clk);
    chk({tag, " valid_drop"}, 32'(out_valid_v[k]), 32'd0);
    chk({tag, " ready_back"}, 32'(in_ready_v[k]), 32'd1);
  endtask

  initial begin
    int  t;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b1;
      a_v[i]         = '0;
      b_v[i]         = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of every instance
    for (int i = 0; i < 3; i++) begin
      chk("rst in_ready", 32'(in_ready_v[i]), 32'd1);
      chk("rst out_valid", 32'(out_valid_v[i]), 32'd0);
      chk("rst c", 32'(c_v[i]), 32'd0);
      chk("rst ovf", 32'(ovf_v[i]), 32'd0);
    end

    // Sign-magnitude, truncate
    run(0, 16'h4000, 16'h4000, 16'h2000, 1'b0, "sm_pos");
    run(0, 16'hC000, 16'h4000, 16'hA000, 1'b0, "sm_neg");
    run(0, 16'h8000, 16'h4000, 16'h0000, 1'b0, "sm_negzero");

    // Two's complement, truncate
    run(1, 16'hC000, 16'h4000, 16'hE000, 1'b0, "tc_neg");
    run(1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, "tc_sat");
    run(1, 16'h8000, 16'h7FFF, 16'h8001, 1'b0, "tc_minval");
    run(1, 16'h0001, 16'h4000, 16'h0000, 1'b0, "tc_trunc");
    run(1, 16'hFFFF, 16'h4000, 16'h0000, 1'b0, "tc_trunc_neg");

    // Two's complement, round half away from zero
    run(2, 16'h0001, 16'h4000, 16'h0001, 1'b0, "tcr_round");
    run(2, 16'hFFFF, 16'h4000, 16'hFFFF, 1'b0, "tcr_round_neg");
    run(2, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, "tcr_sat");

    // Backpressure: result held, spurious in_valid ignored while busy/done
    out_ready_v[0] = 1'b0;
    @(negedge clk);
    a_v[0] = 16'h6000;
    b_v[0] = 16'h2000;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_v[0] = 16'h7FFF;
    b_v[0] = 16'h7FFF;
    t = 0;
    while (!out_valid_v[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("bp latency", 32'(t), 32'd17);
    chk("bp c", 32'(c_v[0]), 32'h1800);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold valid", 32'(out_valid_v[0]), 32'd1);
      chk("bp hold c", 32'(c_v[0]), 32'h1800);
      chk("bp hold ovf", 32'(ovf_v[0]), 32'd0);
      chk("bp in_ready low", 32'(in_ready_v[0]), 32'd0);
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    chk("bp release valid", 32'(out_valid_v[0]), 32'd0);
    chk("bp release ready", 32'(in_ready_v[0]), 32'd1);
    @(negedge clk);
    chk("bp no accept", 32'(in_ready_v[0]), 32'd1);
    chk("bp c kept", 32'(c_v[0]), 32'h1800);

    // Reset during BUSY at count 7 discards the operation
    @(negedge clk);
    a_v[0] = 16'h4000;
    b_v[0] = 16'h4000;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("mid_rst c", 32'(c_v[0]), 32'd0);
    chk("mid_rst ovf", 32'(ovf_v[0]), 32'd0);
    chk("mid_rst in_ready", 32'(in_ready_v[0]), 32'd1);
    ok = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid_v[0]) ok = 1'b0;
    end
    chk("mid_rst no result", 32'(ok), 32'd1);
    run(0, 16'h2000, 16'h2000, 16'h0800, 1'b0, "sm_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
